// File: rtl/atmega_io_arb.sv
// -----------------------------------------------------------------------------
// atmega_io_arb
//
// Two-requester arbiter and access sequencer for the 6-bit ATmega I/O register
// bus. Requester 0 (CPU core) and requester 1 (auxiliary master) share one
// peripheral bus. Each accepted request becomes exactly one single-cycle rd or
// wr strobe, followed by a one-cycle acknowledge to the winning requester.
//
// Sequence per transaction: IDLE (arbitrate, latch) -> ACCESS (strobe high,
// capture read data) -> DONE (ack high, update last-granted) -> IDLE.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous active-low reset
//   m0_req/m1_req       access request, held until the matching ack
//   m0_wr/m1_wr         1 = write, 0 = read
//   m0_addr/m1_addr     register address
//   m0_wdata/m1_wdata   write data
//   m0_ack/m1_ack       one-cycle completion pulse
//   m0_rdata/m1_rdata   read data, valid while ack is high
//   addr                peripheral address (holds last latched value)
//   wr/rd               peripheral write/read strobes
//   bus_in              data to peripheral (holds last latched value)
//   bus_out             data from peripheral, combinationally valid during rd
//
// Parameters
//   BUS_ADDR_DATA_LEN   address width
//   ARB_MODE            "RR" = round-robin, "FIXED" = requester 0 always wins
// -----------------------------------------------------------------------------
module atmega_io_arb #(
  parameter int unsigned BUS_ADDR_DATA_LEN = 6,
  parameter string       ARB_MODE          = "RR"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m0_req,
  input  logic                         m0_wr,
  input  logic [BUS_ADDR_DATA_LEN-1:0] m0_addr,
  input  logic [7:0]                   m0_wdata,
  output logic                         m0_ack,
  output logic [7:0]                   m0_rdata,
  input  logic                         m1_req,
  input  logic                         m1_wr,
  input  logic [BUS_ADDR_DATA_LEN-1:0] m1_addr,
  input  logic [7:0]                   m1_wdata,
  output logic                         m1_ack,
  output logic [7:0]                   m1_rdata,
  output logic [BUS_ADDR_DATA_LEN-1:0] addr,
  output logic                         wr,
  output logic                         rd,
  output logic [7:0]                   bus_in,
  input  logic [7:0]                   bus_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam bit FixedMode = (ARB_MODE == "FIXED");

  state_e                       state_q, state_d;
  logic [BUS_ADDR_DATA_LEN-1:0] addr_q, addr_d;
  logic [7:0]                   bus_in_q, bus_in_d;
  logic                         wr_q, wr_d;
  logic                         rd_q, rd_d;
  logic                         m0_ack_q, m0_ack_d;
  logic                         m1_ack_q, m1_ack_d;
  logic [7:0]                   m0_rdata_q, m0_rdata_d;
  logic [7:0]                   m1_rdata_q, m1_rdata_d;
  logic                         sel_q, sel_d;    // current winner: 0 = m0, 1 = m1
  logic                         last_q, last_d;  // last granted:   0 = m0, 1 = m1
  logic                         pick_m1;

  // Winner selection. Only consulted in IDLE when at least one req is high.
  // In round-robin mode m1 takes a tie only when m0 was served last.
  always_comb begin
    if (FixedMode) pick_m1 = ~m0_req;
    else           pick_m1 = m1_req & (~m0_req | ~last_q);
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bus_in_d   = bus_in_q;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    sel_d      = sel_q;
    last_d     = last_q;

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          sel_d    = pick_m1;
          addr_d   = pick_m1 ? m1_addr  : m0_addr;
          bus_in_d = pick_m1 ? m1_wdata : m0_wdata;
          wr_d     = pick_m1 ? m1_wr    : m0_wr;
          rd_d     = pick_m1 ? ~m1_wr   : ~m0_wr;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // The strobe registers already encode the latched direction.
        if (rd_q) begin
          if (sel_q) m1_rdata_d = bus_out;
          else       m0_rdata_d = bus_out;
        end
        m0_ack_d = ~sel_q;
        m1_ack_d = sel_q;
        state_d  = DONE;
      end
      DONE: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      bus_in_q   <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;  // m0 wins the first tie after reset
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bus_in_q   <= bus_in_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
    end
  end

  assign addr     = addr_q;
  assign bus_in   = bus_in_q;
  assign wr       = wr_q;
  assign rd       = rd_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: doc/atmega_io_arb.md
# atmega_io_arb

Two-requester arbiter and access sequencer for the 6-bit ATmega I/O register bus that feeds peripheral blocks such as atmega_pio. It lets the CPU core (requester 0) and an auxiliary master such as a DMA or bit-bang sequencer (requester 1) share one peripheral bus. Each accepted request becomes exactly one single-cycle rd or wr strobe on the peripheral. The requester gets a one-cycle acknowledge, with read data where applicable.

## Interface
- BUS_ADDR_DATA_LEN, 6: width of address fields.
- ARB_MODE, "RR": "RR" = round-robin; "FIXED" = requester 0 always wins.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (low = reset).
- m0_req  in  1  requester 0 access request; held until m0_ack.
- m0_wr  in  1  1 = write, 0 = read; stable while m0_req.
- m0_addr  in  BUS_ADDR_DATA_LEN  register address.
- m0_wdata  in  8  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  8  read data, valid while m0_ack.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata: same as requester 0, for requester 1.
- addr  out  BUS_ADDR_DATA_LEN  peripheral address.
- wr  out  1  peripheral write strobe.
- rd  out  1  peripheral read strobe.
- bus_in  out  8  data to peripheral.
- bus_out  in  8  data from peripheral; combinationally valid during rd.

## Operation
- FSM states: IDLE, ACCESS, DONE. All outputs registered.
- IDLE
  - No req: stay.
  - Any req: select a winner, latch its wr/addr/wdata into the bus registers, go ACCESS.
- Winner selection
  - ARB_MODE "FIXED": m0 wins whenever m0_req is high.
  - ARB_MODE "RR", one req: that requester wins.
  - ARB_MODE "RR", both req: the requester not granted last wins.
- ACCESS, exactly one cycle
  - wr or rd is high per the latched direction; addr/bus_in hold the latched values.
  - On a read, bus_out is captured into the winner's rdata register at the closing edge.
  - Then go DONE.
- DONE
  - Winner's mX_ack = 1 for one cycle; mX_rdata shows the captured byte (reads) or holds its previous value (writes).
  - Update the last-granted pointer; go IDLE.
- Requester protocol
  - Requester must drop req in the cycle after ack.
  - A req still high in IDLE is a new transaction.
- Loser behaviour: a losing requester keeps req high and is served in the next IDLE with no starvation in RR mode. Maximum wait is 3 cycles after its first IDLE sample.
- addr/bus_in keep the last latched values outside ACCESS; wr = rd = 0 outside ACCESS.
- wr and rd are never high together; at most one ack is high per cycle.
- Req changes during ACCESS/DONE are ignored until IDLE.

## Timing
- Reset values (rst low, asynchronous): state = IDLE, wr = rd = 0, addr = 0, bus_in = 0, m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0, last-granted = requester 1 (so m0 wins the first tie).
- Reset asserted mid-ACCESS: the strobe drops immediately and no ack is issued. The requester must re-request after reset release.
- Latency: req sampled high at edge N → strobe high cycle N..N+1 → ack high cycle N+1..N+2.
- Throughput: one transaction per 3 cycles.
- Back-to-back alternating RR service: m0, m1, m0, … when both hold req continuously.

## Test plan
- Reset: hold rst = 0 with m0_req = 1 → wr = rd = 0, acks 0, rdata 0. After release, first strobe appears 1 cycle after the first sampled req.
- Single write: m0 writes addr 0x01, data 0xFF (PIO DDR) → one wr pulse with addr = 0x01, bus_in = 0xFF, then m0_ack pulse; m1_ack stays 0.
- Read-back: m0 writes 0xAA to 0x00 (PORT), then reads 0x02 (PIN) with all pins output → rd pulse at addr 0x02; m0_rdata = 0xAA during m0_ack.
- Simultaneous requests, RR: m0 and m1 both request from reset (m0 writes 0x00←0x55, m1 writes 0x00←0x33) → m0 served first, m1 next. Final PORT = 0x33; acks 3 cycles apart.
- Sustained contention: both hold req for 6 transactions → grants alternate m0, m1, m0, m1, m0, m1. With ARB_MODE "FIXED", only m0 is served while m0_req is high.
- Reset mid-ACCESS: assert rst during m1's rd strobe → rd falls immediately and m1_ack never pulses. m1 re-requests after release and completes normally.
